// File: rtl/axi_lite_prewrapper_bridge_pkg.sv
// Shared constants and FSM encodings for the AXI4-Lite to prewrapper bridge.
package axi_prewrapper_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi_lite_prewrapper_bridge_if.sv
// AXI4-Lite channel bundle between the host interconnect and the bridge.
interface axi_lite_prewrapper_bridge_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_prewrapper_bridge.sv
// AXI4-Lite slave that turns host transactions into the prewrapper's flat
// word-indexed register port; independent write and read FSMs.
module axi_lite_prewrapper_bridge
  import axi_prewrapper_pkg::*;
#(
  parameter int P_SC_NBR   = 16,
  parameter int NUM_REGS   = P_SC_NBR + 5,
  parameter int ADDR_WIDTH = 12,
  parameter int READ_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  axi_lite_prewrapper_bridge_if.slave  axi,
  output logic [31:0]                  pw_wr_addr,
  output logic [31:0]                  pw_wr_msg,
  output logic [31:0]                  pw_rd_addr,
  input  logic [31:0]                  pw_rd_msg
);

  localparam int          IDX_W      = ADDR_WIDTH - 2;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);
  localparam logic [2:0]  LAT_INIT   = 3'(READ_LAT);

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS_U;
  endfunction

  // Byte-lane bits are ignored by the word decode.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{axi.awaddr[1:0], axi.araddr[1:0]};

  w_state_t          w_state_r, w_state_s;
  logic              aw_held_r, aw_held_s, w_held_r, w_held_s;
  logic [IDX_W-1:0]  awidx_r, awidx_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [3:0]        wstrb_r, wstrb_s;
  logic              awready_r, awready_s, wready_r, wready_s;
  logic              bvalid_r, bvalid_s;
  logic [1:0]        bresp_r, bresp_s;
  logic [31:0]       pw_wr_addr_r, pw_wr_addr_s, pw_wr_msg_r, pw_wr_msg_s;

  r_state_t          r_state_r, r_state_s;
  logic [2:0]        cnt_r, cnt_s;
  logic              arready_r, arready_s, rvalid_r, rvalid_s;
  logic [1:0]        rresp_r, rresp_s;
  logic [31:0]       rdata_r, rdata_s, pw_rd_addr_r, pw_rd_addr_s;

  // Write FSM next state and next registered outputs.
  always_comb begin
    w_state_s    = w_state_r;
    aw_held_s    = aw_held_r;
    w_held_s     = w_held_r;
    awidx_s      = awidx_r;
    wdata_s      = wdata_r;
    wstrb_s      = wstrb_r;
    awready_s    = awready_r;
    wready_s     = wready_r;
    bvalid_s     = bvalid_r;
    bresp_s      = bresp_r;
    pw_wr_addr_s = pw_wr_addr_r;
    pw_wr_msg_s  = pw_wr_msg_r;
    case (w_state_r)
      W_IDLE: begin
        if (axi.awvalid && awready_r) begin
          aw_held_s = 1'b1;
          awidx_s   = axi.awaddr[ADDR_WIDTH-1:2];
          awready_s = 1'b0;
        end else begin
          aw_held_s = aw_held_r;
        end
        if (axi.wvalid && wready_r) begin
          w_held_s = 1'b1;
          wdata_s  = axi.wdata;
          wstrb_s  = axi.wstrb;
          wready_s = 1'b0;
        end else begin
          w_held_s = w_held_r;
        end
        // Commit values are registered on the edge that enters W_COMMIT.
        if (aw_held_s && w_held_s) begin
          w_state_s = W_COMMIT;
          if (idx_in_range(awidx_s) && (wstrb_s == 4'hF)) begin
            pw_wr_addr_s = 32'(awidx_s);
            pw_wr_msg_s  = wdata_s;
            bresp_s      = RESP_OKAY;
          end else begin
            pw_wr_addr_s = IDLE_ADDR;
            bresp_s      = RESP_SLVERR;
          end
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_COMMIT: begin
        w_state_s    = W_RESP;
        bvalid_s     = 1'b1;
        pw_wr_addr_s = IDLE_ADDR;
      end
      W_RESP: begin
        if (axi.bready) begin
          w_state_s = W_IDLE;
          bvalid_s  = 1'b0;
          aw_held_s = 1'b0;
          w_held_s  = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s    = W_IDLE;
        aw_held_s    = 1'b0;
        w_held_s     = 1'b0;
        awready_s    = 1'b1;
        wready_s     = 1'b1;
        bvalid_s     = 1'b0;
        pw_wr_addr_s = IDLE_ADDR;
      end
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_r    <= W_IDLE;
      aw_held_r    <= 1'b0;
      w_held_r     <= 1'b0;
      awidx_r      <= '0;
      wdata_r      <= 32'h0;
      wstrb_r      <= 4'h0;
      awready_r    <= 1'b1;
      wready_r     <= 1'b1;
      bvalid_r     <= 1'b0;
      bresp_r      <= RESP_OKAY;
      pw_wr_addr_r <= IDLE_ADDR;
      pw_wr_msg_r  <= 32'h0;
    end else begin
      w_state_r    <= w_state_s;
      aw_held_r    <= aw_held_s;
      w_held_r     <= w_held_s;
      awidx_r      <= awidx_s;
      wdata_r      <= wdata_s;
      wstrb_r      <= wstrb_s;
      awready_r    <= awready_s;
      wready_r     <= wready_s;
      bvalid_r     <= bvalid_s;
      bresp_r      <= bresp_s;
      pw_wr_addr_r <= pw_wr_addr_s;
      pw_wr_msg_r  <= pw_wr_msg_s;
    end
  end

  // Read FSM next state, latency counter and next registered outputs.
  always_comb begin
    r_state_s    = r_state_r;
    cnt_s        = cnt_r;
    rvalid_s     = rvalid_r;
    rresp_s      = rresp_r;
    rdata_s      = rdata_r;
    pw_rd_addr_s = pw_rd_addr_r;
    case (r_state_r)
      R_IDLE: begin
        if (axi.arvalid && arready_r) begin
          if (idx_in_range(axi.araddr[ADDR_WIDTH-1:2])) begin
            r_state_s    = R_WAIT;
            pw_rd_addr_s = 32'(axi.araddr[ADDR_WIDTH-1:2]);
            cnt_s        = LAT_INIT;
          end else begin
            r_state_s = R_RESP;
            rresp_s   = RESP_SLVERR;
            rdata_s   = 32'h0;
            rvalid_s  = 1'b1;
          end
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (cnt_r <= 3'd1) begin
          r_state_s    = R_RESP;
          cnt_s        = 3'd0;
          rdata_s      = pw_rd_msg;
          rresp_s      = RESP_OKAY;
          rvalid_s     = 1'b1;
          pw_rd_addr_s = IDLE_ADDR;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      R_RESP: begin
        if (axi.rready) begin
          r_state_s = R_IDLE;
          rvalid_s  = 1'b0;
        end else begin
          r_state_s = R_RESP;
        end
      end
      default: begin
        r_state_s    = R_IDLE;
        rvalid_s     = 1'b0;
        pw_rd_addr_s = IDLE_ADDR;
      end
    endcase
    // Hold off reads during the write commit cycle so a read never races it.
    arready_s = (r_state_s == R_IDLE) && (w_state_s != W_COMMIT);
  end

  // Read FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_r    <= R_IDLE;
      cnt_r        <= 3'd0;
      arready_r    <= 1'b1;
      rvalid_r     <= 1'b0;
      rresp_r      <= RESP_OKAY;
      rdata_r      <= 32'h0;
      pw_rd_addr_r <= IDLE_ADDR;
    end else begin
      r_state_r    <= r_state_s;
      cnt_r        <= cnt_s;
      arready_r    <= arready_s;
      rvalid_r     <= rvalid_s;
      rresp_r      <= rresp_s;
      rdata_r      <= rdata_s;
      pw_rd_addr_r <= pw_rd_addr_s;
    end
  end

  assign axi.awready = awready_r;
  assign axi.wready  = wready_r;
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = bresp_r;
  assign axi.arready = arready_r;
  assign axi.rvalid  = rvalid_r;
  assign axi.rresp   = rresp_r;
  assign axi.rdata   = rdata_r;
  assign pw_wr_addr  = pw_wr_addr_r;
  assign pw_wr_msg   = pw_wr_msg_r;
  assign pw_rd_addr  = pw_rd_addr_r;

endmodule

// File: tb/tb_axi_lite_prewrapper_bridge.sv
// Directed bench: table of single transactions plus hand sequences for
// ordering, backpressure and mid-transaction reset; READ_LAT 1 and 3 instances.
module tb_axi_lite_prewrapper_bridge;
  import axi_prewrapper_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  axi_lite_prewrapper_bridge_if #(.ADDR_WIDTH(12)) bus1 ();
  axi_lite_prewrapper_bridge_if #(.ADDR_WIDTH(12)) bus3 ();
  logic [31:0] pw_wr_addr1, pw_wr_msg1, pw_rd_addr1, pw_rd_msg1;
  logic [31:0] pw_wr_addr3, pw_wr_msg3, pw_rd_addr3, pw_rd_msg3;

  axi_lite_prewrapper_bridge #(.READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .axi(bus1),
    .pw_wr_addr(pw_wr_addr1), .pw_wr_msg(pw_wr_msg1),
    .pw_rd_addr(pw_rd_addr1), .pw_rd_msg(pw_rd_msg1)
  );

  axi_lite_prewrapper_bridge #(.READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .axi(bus3),
    .pw_wr_addr(pw_wr_addr3), .pw_wr_msg(pw_wr_msg3),
    .pw_rd_addr(pw_rd_addr3), .pw_rd_msg(pw_rd_msg3)
  );

  // Prewrapper register model: index 3 preset to 0x12345678, others 0xA000_0000|i.
  logic [31:0] mem1 [0:20];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 21; i++)
        mem1[i] <= (i == 3) ? 32'h1234_5678 : (32'hA000_0000 | 32'(i));
    end else if (pw_wr_addr1 < 32'd21) begin
      mem1[pw_wr_addr1[4:0]] <= pw_wr_msg1;
    end
  end
  assign pw_rd_msg1 = (pw_rd_addr1 < 32'd21) ? mem1[pw_rd_addr1[4:0]] : 32'h0;
  assign pw_rd_msg3 = (pw_rd_addr3 == 32'd3) ? 32'h1234_5678 : (32'hA000_0000 | pw_rd_addr3);

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] pw;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [10];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, "_awready"}, 32'(bus1.awready), 32'd1);
    chk({tag, "_wready"},  32'(bus1.wready),  32'd1);
    chk({tag, "_arready"}, 32'(bus1.arready), 32'd1);
    chk({tag, "_bvalid"},  32'(bus1.bvalid),  32'd0);
    chk({tag, "_rvalid"},  32'(bus1.rvalid),  32'd0);
    chk({tag, "_pw_wr"},   pw_wr_addr1, IDLE_ADDR);
    chk({tag, "_pw_rd"},   pw_rd_addr1, IDLE_ADDR);
    chk({tag, "_pw_rd3"},  pw_rd_addr3, IDLE_ADDR);
    chk({tag, "_rvalid3"}, 32'(bus3.rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   lat;
    vecs[0] = '{1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'd2,     32'h0,         2};
    vecs[1] = '{1'b1, 12'h054, 32'h1111_1111, 4'hF, RESP_SLVERR, IDLE_ADDR, 32'h0,         2};
    vecs[2] = '{1'b1, 12'h010, 32'h2222_2222, 4'h3, RESP_SLVERR, IDLE_ADDR, 32'h0,         2};
    vecs[3] = '{1'b1, 12'h050, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   32'd20,    32'h0,         2};
    vecs[4] = '{1'b0, 12'h00C, 32'h0,         4'h0, RESP_OKAY,   32'd3,     32'h1234_5678, 2};
    vecs[5] = '{1'b0, 12'h008, 32'h0,         4'h0, RESP_OKAY,   32'd2,     32'hDEAD_BEEF, 2};
    vecs[6] = '{1'b0, 12'h052, 32'h0,         4'h0, RESP_OKAY,   32'd20,    32'hCAFE_F00D, 2};
    vecs[7] = '{1'b0, 12'h054, 32'h0,         4'h0, RESP_SLVERR, IDLE_ADDR, 32'h0,         1};
    vecs[8] = '{1'b0, 12'h010, 32'h0,         4'h0, RESP_OKAY,   32'd4,     32'hA000_0004, 2};
    vecs[9] = '{1'b0, 12'hFFC, 32'h0,         4'h0, RESP_SLVERR, IDLE_ADDR, 32'h0,         1};

    bus1.awaddr = 12'h0; bus1.awvalid = 1'b0; bus1.wdata = 32'h0; bus1.wstrb = 4'h0;
    bus1.wvalid = 1'b0; bus1.bready = 1'b1; bus1.araddr = 12'h0; bus1.arvalid = 1'b0;
    bus1.rready = 1'b1;
    bus3.awaddr = 12'h0; bus3.awvalid = 1'b0; bus3.wdata = 32'h0; bus3.wstrb = 4'h0;
    bus3.wvalid = 1'b0; bus3.bready = 1'b1; bus3.araddr = 12'h0; bus3.arvalid = 1'b0;
    bus3.rready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_idle1("rst");
    chk("rst_bresp", 32'(bus1.bresp), 32'd0);
    chk("rst_rresp", 32'(bus1.rresp), 32'd0);
    chk("rst_rdata", bus1.rdata, 32'h0);
    chk("rst_pw_msg", pw_wr_msg1, 32'h0);

    // Table of single transactions on the READ_LAT=1 instance.
    for (int k = 0; k < 10; k++) begin
      v = vecs[k];
      if (v.is_wr) begin
        bus1.awaddr = v.addr; bus1.awvalid = 1'b1;
        bus1.wdata = v.data; bus1.wstrb = v.strb; bus1.wvalid = 1'b1;
      end else begin
        bus1.araddr = v.addr; bus1.arvalid = 1'b1;
      end
      tick();
      bus1.awvalid = 1'b0; bus1.wvalid = 1'b0; bus1.arvalid = 1'b0;
      if (v.is_wr) begin
        chk($sformatf("v%0d_commit_addr", k), pw_wr_addr1, v.pw);
        if (v.resp == RESP_OKAY) chk($sformatf("v%0d_commit_msg", k), pw_wr_msg1, v.data);
        chk($sformatf("v%0d_awready_low", k), 32'(bus1.awready), 32'd0);
      end else begin
        chk($sformatf("v%0d_rd_addr", k), pw_rd_addr1, v.pw);
      end
      lat = 1;
      while (!(v.is_wr ? bus1.bvalid : bus1.rvalid) && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.lat));
      if (v.is_wr) begin
        chk($sformatf("v%0d_bresp", k), 32'(bus1.bresp), 32'(v.resp));
        chk($sformatf("v%0d_pw_wr_idle", k), pw_wr_addr1, IDLE_ADDR);
      end else begin
        chk($sformatf("v%0d_rresp", k), 32'(bus1.rresp), 32'(v.resp));
        chk($sformatf("v%0d_rdata", k), bus1.rdata, v.rdata);
        chk($sformatf("v%0d_pw_rd_idle", k), pw_rd_addr1, IDLE_ADDR);
      end
      tick();
      chk($sformatf("v%0d_valid_drop", k),
          32'(v.is_wr ? bus1.bvalid : bus1.rvalid), 32'd0);
    end

    // W three cycles ahead of AW.
    bus1.wdata = 32'h55AA_55AA; bus1.wstrb = 4'hF; bus1.wvalid = 1'b1;
    tick();
    bus1.wvalid = 1'b0;
    chk("wfirst_wready_low", 32'(bus1.wready), 32'd0);
    chk("wfirst_awready_high", 32'(bus1.awready), 32'd1);
    repeat (2) tick();
    chk("wfirst_wready_held", 32'(bus1.wready), 32'd0);
    chk("wfirst_no_bvalid", 32'(bus1.bvalid), 32'd0);
    chk("wfirst_no_commit", pw_wr_addr1, IDLE_ADDR);
    bus1.awaddr = 12'h004; bus1.awvalid = 1'b1;
    tick();
    bus1.awvalid = 1'b0;
    chk("wfirst_commit_addr", pw_wr_addr1, 32'd1);
    chk("wfirst_commit_msg", pw_wr_msg1, 32'h55AA_55AA);
    tick();
    chk("wfirst_bvalid", 32'(bus1.bvalid), 32'd1);
    chk("wfirst_bresp", 32'(bus1.bresp), 32'(RESP_OKAY));
    tick();
    chk("wfirst_bvalid_drop", 32'(bus1.bvalid), 32'd0);
    chk("wfirst_readys_back", 32'({bus1.awready, bus1.wready}), 32'd3);
    repeat (3) tick();
    chk("wfirst_single_resp", 32'(bus1.bvalid), 32'd0);

    // AR offered during the write commit to index 5.
    bus1.awaddr = 12'h014; bus1.wdata = 32'h0BAD_CAFE; bus1.wstrb = 4'hF;
    bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    tick();
    bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    bus1.araddr = 12'h014; bus1.arvalid = 1'b1;
    chk("order_arready_low", 32'(bus1.arready), 32'd0);
    chk("order_commit_addr", pw_wr_addr1, 32'd5);
    tick();
    chk("order_arready_high", 32'(bus1.arready), 32'd1);
    chk("order_bvalid", 32'(bus1.bvalid), 32'd1);
    tick();
    bus1.arvalid = 1'b0;
    chk("order_rd_addr", pw_rd_addr1, 32'd5);
    tick();
    chk("order_rvalid", 32'(bus1.rvalid), 32'd1);
    chk("order_rdata", bus1.rdata, 32'h0BAD_CAFE);
    tick();

    // READ_LAT=3 instance.
    bus3.araddr = 12'h00C; bus3.arvalid = 1'b1;
    tick();
    bus3.arvalid = 1'b0;
    chk("lat3_rd_addr", pw_rd_addr3, 32'd3);
    lat = 1;
    while (!bus3.rvalid && lat < 10) begin
      tick();
      lat++;
    end
    chk("lat3_latency", 32'(lat), 32'd4);
    chk("lat3_rdata", bus3.rdata, 32'h1234_5678);
    chk("lat3_rresp", 32'(bus3.rresp), 32'(RESP_OKAY));
    tick();
    chk("lat3_rvalid_drop", 32'(bus3.rvalid), 32'd0);

    // Backpressure on both channels, then reset mid-response.
    bus1.bready = 1'b0; bus1.rready = 1'b0;
    bus1.awaddr = 12'h018; bus1.wdata = 32'h7777_7777; bus1.wstrb = 4'hF;
    bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    bus1.araddr = 12'h00C; bus1.arvalid = 1'b1;
    tick();
    bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    bus1.araddr = 12'h008;
    repeat (2) tick();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d_bvalid", c), 32'(bus1.bvalid), 32'd1);
      chk($sformatf("stall%0d_bresp", c), 32'(bus1.bresp), 32'(RESP_OKAY));
      chk($sformatf("stall%0d_rvalid", c), 32'(bus1.rvalid), 32'd1);
      chk($sformatf("stall%0d_rdata", c), bus1.rdata, 32'h1234_5678);
      chk($sformatf("stall%0d_arready", c), 32'(bus1.arready), 32'd0);
      chk($sformatf("stall%0d_awready", c), 32'(bus1.awready), 32'd0);
      tick();
    end
    bus1.arvalid = 1'b0;
    bus3.araddr = 12'h00C; bus3.arvalid = 1'b1;
    tick();
    bus3.arvalid = 1'b0;
    chk("prerst_rd_addr3", pw_rd_addr3, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk_idle1("async_rst");
    tick();
    @(negedge clk);
    reset = 1'b0;
    bus1.bready = 1'b1; bus1.rready = 1'b1;
    repeat (5) tick();
    chk_idle1("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_prewrapper_bridge.md
Name: axi_lite_prewrapper_bridge

Overview:
- AXI4-Lite slave front end that sits directly upstream of the scan-test prewrapper.
- Converts AXI4-Lite write/read transactions from the host interconnect into the prewrapper's flat register port: pw_wr_addr/pw_wr_msg for writes, pw_rd_addr/pw_rd_msg for reads.
- Has independent write and read FSMs, one-transaction-outstanding per channel, with OKAY/SLVERR responses.

Parameters:
- P_SC_NBR, 16, number of scan chains; sets the register count.
- NUM_REGS, P_SC_NBR+5, number of 32-bit word registers decoded in the prewrapper.
- ADDR_WIDTH, 12, AXI byte-address width.
- READ_LAT, 1, cycles from pw_rd_addr valid to pw_rd_msg sample (1..4).
- IDLE_ADDR, 32'hFFFF_FFFF, value driven on pw_wr_addr/pw_rd_addr when no access is in progress; decodes to no register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1 / s_axi_awready  out  1
- s_axi_wdata  in  32 / s_axi_wstrb  in  4 / s_axi_wvalid  in  1 / s_axi_wready  out  1
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1
- s_axi_araddr  in  ADDR_WIDTH / s_axi_arvalid  in  1 / s_axi_arready  out  1
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1
- pw_wr_addr  out  32  word index to prewrapper write port
- pw_wr_msg  out  32  write data to prewrapper
- pw_rd_addr  out  32  word index to prewrapper read port
- pw_rd_msg  in  32  read data from prewrapper, combinational from pw_rd_addr

Behaviour:
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, pw_wr_addr=pw_rd_addr=IDLE_ADDR, pw_wr_msg=0. All outputs are registered.
- Address decode: index = addr[ADDR_WIDTH-1:2]. addr[1:0] is ignored. index >= NUM_REGS is out of range.
- Write FSM, states W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. Each ready drops after its own handshake, and the latched value is held. Once both are held, go to W_COMMIT.
  - W_COMMIT (exactly 1 cycle): if index is in range and wstrb==4'hF, drive pw_wr_addr=index and pw_wr_msg=wdata, with bresp=OKAY. Otherwise pw_wr_addr stays IDLE_ADDR and bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1 and pw_wr_addr back to IDLE_ADDR. On bvalid&&bready, go to W_IDLE and re-raise awready/wready.
  - Minimum latency: last of AW/W handshake at cycle N -> commit at N+1 -> bvalid at N+2.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1 except while the write FSM is in W_COMMIT; in that cycle arready=0.
  - On AR handshake: in range -> drive pw_rd_addr=index, load a counter with READ_LAT, go to R_WAIT. Out of range -> rresp=SLVERR, rdata=0, go straight to R_RESP.
  - R_WAIT: decrement the counter. When it reaches 0, register rdata=pw_rd_msg and rresp=OKAY, restore pw_rd_addr=IDLE_ADDR, go to R_RESP.
  - R_RESP: rvalid=1, rdata/rresp held stable. On rvalid&&rready, go to R_IDLE.
  - Latency with READ_LAT=1: AR at N -> rvalid at N+2.
- Read/write ordering:
  - A read accepted in the same cycle a write commits is not possible, because arready=0 then.
  - A read to an address written earlier returns the new value, since the commit precedes the read by at least 1 cycle.
  - Both FSMs otherwise run concurrently.
- Backpressure: bvalid/rvalid stay high indefinitely until ready; no new transaction is accepted on that channel meanwhile.
- Reset mid-transaction: all FSMs return to IDLE immediately. Pending responses are dropped, and pw_* addresses go to IDLE_ADDR asynchronously.

Decomposition:
- Package axi_prewrapper_pkg holds:
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - write-state and read-state encodings;
  - IDLE_ADDR constant.
- No sub-module: one module with two FSMs and a READ_LAT down-counter.

Test Plan:
- AW and W in the same cycle, awaddr=0x008, wdata=0xDEADBEEF, wstrb=F -> pw_wr_addr=2, pw_wr_msg=0xDEADBEEF for exactly 1 cycle; bvalid 2 cycles later with bresp=OKAY.
- W issued 3 cycles before AW (addr 0x004) -> wready low after the W handshake; commit 1 cycle after AW; single OKAY response.
- Write with wstrb=4'h3 and write to addr 0x054 (index 21 >= NUM_REGS) -> pw_wr_addr stays IDLE_ADDR; bresp=SLVERR.
- Read of addr 0x00C with a model returning 0x1234_5678 at index 3, READ_LAT=1 and 3 -> rvalid at N+2 and N+4, rdata=0x12345678, OKAY. Out-of-range read -> SLVERR, rdata=0.
- AR offered in the same cycle as a write commit to index 5, then read of index 5 -> arready low for that cycle; read returns the newly written data.
- bready and rready held low for 10 cycles, then reset asserted mid-response -> responses held stable while stalled; after reset, all readys=1, valids=0, pw addresses=IDLE_ADDR.
